// File: rtl/multipack_pkg.sv
// Shared types for the multipack arbiter: the 3-bit request word and its evaluation mask.
package multipack_pkg;

  // Field c is the top bit so that the mask covers only a and b.
  typedef struct packed {
    logic c;
    logic b;
    logic a;
  } struct_t;

  typedef union packed {
    logic [2:0] raw;
    struct_t    fields;
  } union_t;

  localparam logic [2:0] EVAL_MASK = 3'b011;

endpackage

// File: rtl/multipack_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or above ptr, wrapping to lane 0.
module rr_pick #(
  parameter int COUNT  = 4,
  parameter int LANE_W = $clog2(COUNT)
) (
  input  logic [COUNT-1:0]  req,
  input  logic [LANE_W-1:0] ptr,
  output logic [COUNT-1:0]  grant,
  output logic [LANE_W-1:0] idx,
  output logic              any
);

  logic [COUNT-1:0]  upper;
  logic [COUNT:0]    hi_seen;
  logic [COUNT:0]    lo_seen;
  logic [COUNT-1:0]  hi_grant;
  logic [COUNT-1:0]  lo_grant;
  logic [LANE_W-1:0] idx_acc [COUNT+1];

  assign hi_seen[0] = 1'b0;
  assign lo_seen[0] = 1'b0;
  assign idx_acc[0] = '0;

  // Two find-first chains: one over lanes >= ptr, one over all lanes as the wrap fallback.
  for (genvar gi = 0; gi < COUNT; gi++) begin : g_lane
    assign upper[gi]      = req[gi] && (LANE_W'(gi) >= ptr);
    assign hi_grant[gi]   = upper[gi] && !hi_seen[gi];
    assign hi_seen[gi+1]  = hi_seen[gi] || upper[gi];
    assign lo_grant[gi]   = req[gi] && !lo_seen[gi];
    assign lo_seen[gi+1]  = lo_seen[gi] || req[gi];
    assign idx_acc[gi+1]  = idx_acc[gi] | (grant[gi] ? LANE_W'(gi) : '0);
  end

  assign grant = hi_seen[COUNT] ? hi_grant : lo_grant;
  assign idx   = idx_acc[COUNT];
  assign any   = lo_seen[COUNT];

endmodule

// File: rtl/multipack_arbiter.sv
// Round-robin shared mask-and-evaluate unit with a one-deep valid/ready result slot
// and a sticky per-lane result vector.
module multipack_arbiter
  import multipack_pkg::*;
#(
  parameter int COUNT  = 4,
  parameter int LANE_W = $clog2(COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COUNT-1:0]        req_valid,
  input  union_t [COUNT-1:0]      req_data,
  output logic [COUNT-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [LANE_W-1:0]       res_lane,
  output logic                    res_hit,
  output logic                    res_bit,
  output logic [COUNT-1:0]        out
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_reg, state_next;
  logic [LANE_W-1:0] ptr_reg, ptr_next;
  logic [LANE_W-1:0] res_lane_reg, res_lane_next;
  logic              res_hit_reg, res_hit_next;
  logic              res_bit_reg, res_bit_next;
  logic [COUNT-1:0]  out_reg, out_next;

  logic [COUNT-1:0]  pick_grant;
  logic [LANE_W-1:0] pick_idx;
  logic              pick_any;
  logic              slot_free;
  logic              do_grant;
  logic [2:0]        sel_acc [COUNT+1];
  union_t            sel_word;
  logic              eval_hit;
  logic              eval_bit;

  rr_pick #(
    .COUNT  (COUNT),
    .LANE_W (LANE_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // rst_n gates the grant so nothing handshakes during the reset cycle.
  assign slot_free = (state_reg == EMPTY) || res_ready;
  assign do_grant  = slot_free && pick_any && rst_n;
  assign req_ready = do_grant ? pick_grant : '0;

  assign sel_acc[0] = 3'b000;
  for (genvar gi = 0; gi < COUNT; gi++) begin : g_sel
    assign sel_acc[gi+1] = sel_acc[gi] | (pick_grant[gi] ? req_data[gi].raw : 3'b000);
    assign out_next[gi]  = (req_ready[gi] && eval_hit) ? eval_bit : out_reg[gi];
  end

  assign sel_word.raw = sel_acc[COUNT];
  assign eval_hit     = |(sel_word.raw & EVAL_MASK);
  assign eval_bit     = eval_hit && (sel_word.fields.a ^ sel_word.fields.b);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    res_lane_next = res_lane_reg;
    res_hit_next  = res_hit_reg;
    res_bit_next  = res_bit_reg;
    if (do_grant) begin
      state_next    = FULL;
      res_lane_next = pick_idx;
      res_hit_next  = eval_hit;
      res_bit_next  = eval_bit;
      ptr_next      = (pick_idx == LANE_W'(COUNT - 1)) ? '0 : pick_idx + LANE_W'(1);
    end else if ((state_reg == FULL) && res_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      ptr_reg      <= '0;
      res_lane_reg <= '0;
      res_hit_reg  <= 1'b0;
      res_bit_reg  <= 1'b0;
      out_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      res_lane_reg <= res_lane_next;
      res_hit_reg  <= res_hit_next;
      res_bit_reg  <= res_bit_next;
      out_reg      <= out_next;
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_lane  = res_lane_reg;
  assign res_hit   = res_hit_reg;
  assign res_bit   = res_bit_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_multipack_arbiter.sv
// Directed bench for multipack_arbiter: a stimulus process pushes expected results,
// a monitor pops and compares them when the result slot is consumed.
module tb_multipack_arbiter;
  import multipack_pkg::*;

  typedef struct packed {
    logic [1:0] lane;
    logic       hit;
    logic       bitv;
    logic [3:0] out;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req_valid;
  union_t [3:0]   req_data;
  logic [3:0]     req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_lane;
  logic           res_hit;
  logic           res_bit;
  logic [3:0]     out;

  logic [2:0]     req_valid3;
  union_t [2:0]   req_data3;
  logic [2:0]     req_ready3;
  logic           res_valid3;
  logic           res_ready3;
  logic [1:0]     res_lane3;
  logic           res_hit3;
  logic           res_bit3;
  logic [2:0]     out3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic mv;
  logic [3:0] model_out;

  always #5 clk = ~clk;

  multipack_arbiter #(.COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_lane(res_lane), .res_hit(res_hit), .res_bit(res_bit), .out(out)
  );

  multipack_arbiter #(.COUNT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_lane(res_lane3), .res_hit(res_hit3), .res_bit(res_bit3), .out(out3)
  );

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("mon_unexpected", 1'b0, {27'd0, res_lane, res_hit, res_bit, 1'b0}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mon_result", {res_lane, res_hit, res_bit, out} === {e.lane, e.hit, e.bitv, e.out},
            {24'd0, res_lane, res_hit, res_bit, out}, {24'd0, e.lane, e.hit, e.bitv, e.out});
        $display("txn lane=%0d hit=%0b bit=%0b out=%b", res_lane, res_hit, res_bit, out);
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic drive(input logic [3:0] v, input logic [11:0] data, input logic rdy, input int exp_lane);
    logic [3:0] exp_rr;
    logic [2:0] w;
    exp_t       e;
    req_valid = v;
    for (int i = 0; i < 4; i++) req_data[i].raw = data[i*3 +: 3];
    res_ready = rdy;
    exp_rr = (exp_lane < 0) ? 4'b0000 : (4'b0001 << exp_lane);
    @(negedge clk);
    chk("req_ready", req_ready === exp_rr, {28'd0, req_ready}, {28'd0, exp_rr});
    chk("res_valid", res_valid === mv, {31'd0, res_valid}, {31'd0, mv});
    if (mv)
      chk("res_held", {res_lane, res_hit, res_bit, out} === {last_exp.lane, last_exp.hit, last_exp.bitv, last_exp.out},
          {24'd0, res_lane, res_hit, res_bit, out}, {24'd0, last_exp.lane, last_exp.hit, last_exp.bitv, last_exp.out});
    if (exp_lane >= 0) begin
      w = data[exp_lane*3 +: 3];
      e.lane = exp_lane[1:0];
      e.hit  = (w[1:0] != 2'b00);
      e.bitv = e.hit && (w[0] != w[1]);
      if (e.hit) model_out[exp_lane] = e.bitv;
      e.out = model_out;
      sb_q.push_back(e);
      last_exp = e;
      mv = 1'b1;
    end else if (rdy) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp3 [4];
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = '0;
    res_ready  = 1'b1;
    req_valid3 = 3'b000;
    req_data3  = '0;
    res_ready3 = 1'b1;
    mv         = 1'b0;
    model_out  = 4'b0000;
    last_exp   = '0;

    // Reset held two cycles with every lane requesting.
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", req_ready === 4'b0000, {28'd0, req_ready}, 32'd0);
      chk("rst_state", {res_valid, res_lane, res_hit, res_bit, out} === 9'd0,
          {23'd0, res_valid, res_lane, res_hit, res_bit, out}, 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    drive(4'b1111, 12'h000, 1'b1, 0);
    // Hit then miss on lane 2.
    drive(4'b0100, {3'b000, 3'b001, 3'b000, 3'b000}, 1'b1, 2);
    drive(4'b0100, {3'b000, 3'b100, 3'b000, 3'b000}, 1'b1, 2);
    drive(4'b1000, {3'b111, 3'b000, 3'b000, 3'b000}, 1'b1, 3);
    // Round-robin with all lanes requesting.
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 0);
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 1);
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 2);
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 3);
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 0);
    drive(4'b1111, {3'b111, 3'b001, 3'b010, 3'b011}, 1'b1, 1);
    // Backpressure, then lane 3 granted on the release cycle.
    repeat (3) drive(4'b1010, {3'b101, 3'b000, 3'b010, 3'b000}, 1'b0, -1);
    drive(4'b1010, {3'b101, 3'b000, 3'b010, 3'b000}, 1'b1, 3);
    drive(4'b0100, {3'b000, 3'b011, 3'b000, 3'b000}, 1'b1, 2);
    drive(4'b0000, 12'h000, 1'b0, -1);
    chk("pre_reset_out", model_out === 4'b1010, {28'd0, model_out}, 32'ha);

    // Reset while FULL with a held result.
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    res_ready = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", req_ready === 4'b0000, {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    sb_q.delete();
    mv = 1'b0;
    model_out = 4'b0000;
    @(negedge clk);
    chk("midrst_state", {res_valid, out} === 5'd0, {27'd0, res_valid, out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0110, {3'b000, 3'b000, 3'b010, 3'b000}, 1'b1, 1);
    drive(4'b0000, 12'h000, 1'b1, -1);
    chk("sb_drained", sb_q.size() == 0, sb_q.size(), 32'd0);

    // COUNT=3: lanes 0 and 2 alternate across the non-power-of-two wrap.
    exp3[0] = 0; exp3[1] = 2; exp3[2] = 0; exp3[3] = 2;
    req_valid3 = 3'b101;
    req_data3[0].raw = 3'b001;
    req_data3[2].raw = 3'b010;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] e3;
      e3 = 3'b001 << exp3[i];
      @(negedge clk);
      chk("c3_grant", req_ready3 === e3, {29'd0, req_ready3}, {29'd0, e3});
      if (i > 0)
        chk("c3_res_lane", res_valid3 === 1'b1 && res_lane3 === 2'(exp3[i-1]),
            {29'd0, res_valid3, res_lane3}, {29'd0, 1'b1, 2'(exp3[i-1])});
      @(posedge clk);
      #1;
    end
    req_valid3 = 3'b000;
    @(negedge clk);
    chk("c3_out", out3 === 3'b101 && res_lane3 === 2'd2, {27'd0, res_lane3, out3}, {27'd0, 2'd2, 3'b101});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multipack_arbiter.md
# multipack_arbiter

Round-robin scheduler that shares one mask-and-evaluate unit among `COUNT` requesters, each presenting a packed 3-bit union word. A granted word is checked against mask `3'b011`. If any masked bit is set, the unit computes `fields.a ^ fields.b`. The block returns a per-transaction result through a valid/ready output stage and keeps a sticky per-lane result vector. It sits between lane producers and the lane-status consumers, replacing a fully replicated per-lane evaluator.

## Interface
Parameters:
- `COUNT`, default 4: number of requesting lanes; legal range 2..32.
- `LANE_W`, default `$clog2(COUNT)`: lane index width. Derived; never overridden.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `req_valid`  input  COUNT  per-lane request.
- `req_data`  input  COUNT x union_t  per-lane packed word (`raw[2:0]` / `fields{a,b,c}`).
- `req_ready`  output  COUNT  one-hot grant; zero or one bit high.
- `res_valid`  output  1  result register holds a transaction.
- `res_ready`  input  1  consumer accepts the result.
- `res_lane`  output  LANE_W  lane of held result.
- `res_hit`  output  1  `(raw & 3'b011) != 0` for held result.
- `res_bit`  output  1  `fields.a ^ fields.b` when `res_hit`; 0 otherwise.
- `out`  output  COUNT  sticky per-lane result.

## Operation
- Slot free when `!res_valid || res_ready`.
- Grant: if slot free, pick the first lane with `req_valid` set, searching from `ptr` upward with wrap modulo `COUNT`. Set that lane's `req_ready`. The handshake completes that cycle.
- `req_ready` is combinational from `req_valid`, `ptr`, and slot state. It is all-zero while slot is busy or while `rst_n` is low.
- On grant of lane g:
  - Load the result register: `res_valid=1`, `res_lane=g`, `res_hit`, `res_bit`.
  - Set `ptr <= (g==COUNT-1) ? 0 : g+1`. Wrap is explicit; `COUNT` need not be a power of two.
- On the same edge, if `res_hit`, `out[g] <= res_bit`. On a miss, `out[g]` holds its previous value (hold-last semantics).
- If the slot is consumed (`res_valid && res_ready`) with no new grant, `res_valid <= 0`.
- If consume and grant happen in the same cycle, the new result replaces the old. There is no bubble.
- With no requests, `ptr` holds.
- Two-state view:
  - EMPTY (`res_valid=0`): grant whenever any `req_valid` is set.
  - FULL (`res_valid=1`): grant only if `res_ready`. With no grant and `res_ready`, go to EMPTY. Otherwise stay FULL with result fields stable.
- Bit `c` is ignored by both mask and compute.

## Timing
- Reset, sampled on a clk edge with `rst_n=0`:
  - `res_valid=0`, `res_lane=0`, `res_hit=0`, `res_bit=0`, `out=0`, `ptr=0`.
  - `req_ready=0` for the whole reset cycle.
- Reset mid-operation drops any held result without handshake. Requests presented during reset are not granted.
- Latency: grant in cycle N, result visible in N+1. `out` reflects the update in N+1.
- Throughput: one transaction per cycle while `res_ready=1`.
- Fairness: a continuously requesting lane waits at most `COUNT-1` grants.
- While FULL and `!res_ready`, `res_*` and `out` are stable.
- A producer holds `req_valid`/`req_data` until `req_ready`. The arbiter does not depend on this.

## Structure
- Package `multipack_pkg`: `struct_t` (`a`, `b`, `c`), `union_t` (`raw[2:0]` / `fields`), constant `EVAL_MASK = 3'b011`.
- Sub-module `rr_pick`: parameter `COUNT`.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant, encoded index, any-grant flag.
  - Purely combinational.
- Top level holds `ptr`, the result register, `out`, and the evaluate logic (mask test, XOR).

## Test plan
- **Reset:** drive `rst_n=0` for 2 cycles with all `req_valid=1`. Expect `req_ready=0`, `res_valid=0`, `out=0`. After release, lane 0 is granted first.
- **Hit/miss:** COUNT=4. Lane 2 sends `raw=3'b001`, giving `res_hit=1`, `res_bit=1`, `out=4'b0100`. Lane 2 then sends `3'b100`, giving `res_hit=0`, `res_bit=0`, and `out` stays `4'b0100`.
- **Round-robin:** all 4 lanes request continuously with `res_ready=1`. Expect grant order 0,1,2,3,0,1. Expect `res_valid` high every cycle from the cycle after the first grant.
- **Backpressure:** hold `res_ready=0` for 3 cycles with lanes 1 and 3 requesting. Expect `req_ready=0` and `res_*` stable. When `res_ready` rises, expect lane 3 granted in that same cycle.
- **Non-power-of-two wrap:** COUNT=3, lanes 0 and 2 requesting. Expect grants 0,2,0,2 and `ptr` never reaching 3.
- **Reset mid-operation:** assert `rst_n=0` while FULL with `out=4'b1010`. Next cycle expect `res_valid=0`, `out=0`, and the first grant after release goes to the lowest requesting lane.
